bloom_filter_lut_clear_ctrl: RTL and testbench

Sequencer and write arbiter for the bloom filter LUT port. It sits between the host Avalon-MM LUT slave path and the filter's `amm_slave_lut_*` inputs, in the `main_clk_i` domain. It passes host LUT writes through in normal operation. On command, it holds the datapath, waits for it to drain, then sweeps every LUT address with a fill word, stalling the host until the sweep finishes.

---
 rtl/bloom_filter_lut_clear_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_bloom_filter_lut_clear_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_filter_lut_clear_ctrl.sv
// -----------------------------------------------------------------------------
// bloom_filter_lut_clear_ctrl
//
// Sits between the host Avalon-MM LUT write path and the bloom filter LUT
// slave. Normally it registers host writes straight through to the filter.
// When a clear is requested it does three things in order:
//    1. Holds the filter input.
//    2. Waits for the filter datapath to drain.
//    3. Writes the fill word to every LUT address, one write per clock.
// The host is stalled with waitrequest until the sweep is finished.
//
// Optional feature macro: BLOOM_LUT_CLEAR_STATS_EN
//    When defined, this block adds a completed-clear counter (clear_cnt_o).
//    It also adds a sticky flag (clear_drop_o) that records clear requests
//    which were ignored because a clear was already in progress.
//
// Parameters
//    AMM_LUT_ADDR_W : LUT address width; the sweep covers 2^AMM_LUT_ADDR_W words
//    AMM_LUT_DATA_W : LUT write-data width
//    CLEAR_DATA     : fill word written during the sweep
//
// Ports
//    main_clk_i                 : block clock
//    main_rst_i                 : asynchronous active-high reset
//    start_clear_i              : one-cycle clear request (honoured in IDLE only)
//    filter_idle_i              : filter datapath has no in-flight lookups
//    filter_hold_o              : stall new packet acceptance into the filter
//    clear_busy_o               : clear in progress
//    clear_done_o               : one-cycle pulse when the sweep completes
//    host_lut_address_i         : host write address
//    host_lut_write_i           : host write strobe
//    host_lut_writedata_i       : host write data
//    host_lut_waitrequest_o     : stall to the host (high outside IDLE)
//    amm_master_lut_address_o   : registered LUT address to the filter
//    amm_master_lut_write_o     : registered LUT write strobe to the filter
//    amm_master_lut_writedata_o : registered LUT write data to the filter
//    clear_cnt_o                : (stats build) completed clears, wraps at 16 bits
//    clear_drop_o               : (stats build) sticky ignored-request flag
//
// State table
//    state | meaning
//    IDLE  | host writes pass through; a clear request moves to HOLD
//    HOLD  | filter held, host stalled; waits for filter_idle_i
//    SWEEP | writes CLEAR_DATA to addresses 0 .. 2^AMM_LUT_ADDR_W-1
//    DONE  | clear_done_o pulse; hold and busy still asserted
// -----------------------------------------------------------------------------
module bloom_filter_lut_clear_ctrl #(
   parameter int                        AMM_LUT_ADDR_W = 10,
   parameter int                        AMM_LUT_DATA_W = 32,
   parameter logic [AMM_LUT_DATA_W-1:0] CLEAR_DATA     = '0
) (
   input  logic                      main_clk_i,
   input  logic                      main_rst_i,
   input  logic                      start_clear_i,
   input  logic                      filter_idle_i,
   output logic                      filter_hold_o,
   output logic                      clear_busy_o,
   output logic                      clear_done_o,
   input  logic [AMM_LUT_ADDR_W-1:0] host_lut_address_i,
   input  logic                      host_lut_write_i,
   input  logic [AMM_LUT_DATA_W-1:0] host_lut_writedata_i,
   output logic                      host_lut_waitrequest_o,
   output logic [AMM_LUT_ADDR_W-1:0] amm_master_lut_address_o,
   output logic                      amm_master_lut_write_o,
   output logic [AMM_LUT_DATA_W-1:0] amm_master_lut_writedata_o
`ifdef BLOOM_LUT_CLEAR_STATS_EN
   ,
   output logic [15:0]               clear_cnt_o,
   output logic                      clear_drop_o
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      SWEEP = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AMM_LUT_ADDR_W-1:0] ADDR_ONE = {{(AMM_LUT_ADDR_W-1){1'b0}}, 1'b1};

   state_t                    state;

   // sweep_addr holds the address currently being driven on the master port
   // during SWEEP. Once the all-ones address has been issued, it wraps back
   // to zero.
   logic [AMM_LUT_ADDR_W-1:0] sweep_addr;
   logic [AMM_LUT_ADDR_W-1:0] sweep_next;
   logic                      sweep_last;

   assign sweep_next = sweep_addr + ADDR_ONE;
   assign sweep_last = &sweep_addr;

   // Waitrequest is taken from the state register, so a host write held
   // during a clear is accepted on the first cycle back in IDLE.
   assign host_lut_waitrequest_o = (state != IDLE);

   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         state                      <= IDLE;
         sweep_addr                 <= '0;
         filter_hold_o              <= 1'b0;
         clear_busy_o               <= 1'b0;
         clear_done_o               <= 1'b0;
         amm_master_lut_address_o   <= '0;
         amm_master_lut_write_o     <= 1'b0;
         amm_master_lut_writedata_o <= '0;
      end else begin
         // Strobes are one-cycle; each branch re-asserts them when needed.
         amm_master_lut_write_o <= 1'b0;
         clear_done_o           <= 1'b0;

         case (state)
            IDLE: begin
               // A host write that arrives together with a clear request is
               // still issued. The sweep that follows overwrites it.
               if (host_lut_write_i) begin
                  amm_master_lut_write_o     <= 1'b1;
                  amm_master_lut_address_o   <= host_lut_address_i;
                  amm_master_lut_writedata_o <= host_lut_writedata_i;
               end
               if (start_clear_i) begin
                  state         <= HOLD;
                  filter_hold_o <= 1'b1;
                  clear_busy_o  <= 1'b1;
               end
            end

            HOLD: begin
               // Address 0 is issued on the same edge that enters SWEEP.
               if (filter_idle_i) begin
                  state                      <= SWEEP;
                  sweep_addr                 <= '0;
                  amm_master_lut_write_o     <= 1'b1;
                  amm_master_lut_address_o   <= '0;
                  amm_master_lut_writedata_o <= CLEAR_DATA;
               end
            end

            SWEEP: begin
               sweep_addr <= sweep_next;
               if (sweep_last) begin
                  state        <= DONE;
                  clear_done_o <= 1'b1;
               end else begin
                  amm_master_lut_write_o     <= 1'b1;
                  amm_master_lut_address_o   <= sweep_next;
                  amm_master_lut_writedata_o <= CLEAR_DATA;
               end
            end

            DONE: begin
               state         <= IDLE;
               filter_hold_o <= 1'b0;
               clear_busy_o  <= 1'b0;
            end

            default: begin
               state         <= IDLE;
               filter_hold_o <= 1'b0;
               clear_busy_o  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BLOOM_LUT_CLEAR_STATS_EN
   // Stats are cleared only by reset. Requests are not queued, so any request
   // seen outside IDLE counts as dropped.
   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         clear_cnt_o  <= 16'd0;
         clear_drop_o <= 1'b0;
      end else begin
         if (state == DONE) begin
            clear_cnt_o <= clear_cnt_o + 16'd1;
         end
         if (start_clear_i && (state != IDLE)) begin
            clear_drop_o <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bloom_filter_lut_clear_ctrl.sv
// Bench for bloom_filter_lut_clear_ctrl (AMM_LUT_ADDR_W=4, CLEAR_DATA=A5A5A5A5).
// The driver computes, from the clear timing rules, the cycle on which every
// master write and done pulse must appear and queues it. A negedge monitor
// pops and compares against whatever the DUT presents.
module tb_bloom_filter_lut_clear_ctrl;

   localparam int          AW    = 4;
   localparam int          DW    = 32;
   localparam int          NWORD = 1 << AW;
   localparam logic [31:0] FILL  = 32'hA5A5A5A5;

   logic          clk;
   logic          rst;
   logic          start_clear;
   logic          filter_idle;
   logic          filter_hold;
   logic          clear_busy;
   logic          clear_done;
   logic [AW-1:0] host_address;
   logic          host_write;
   logic [DW-1:0] host_writedata;
   logic          host_waitrequest;
   logic [AW-1:0] m_address;
   logic          m_write;
   logic [DW-1:0] m_writedata;
`ifdef BLOOM_LUT_CLEAR_STATS_EN
   logic [15:0]   clear_cnt;
   logic          clear_drop;
`endif

   bloom_filter_lut_clear_ctrl #(
      .AMM_LUT_ADDR_W (AW),
      .AMM_LUT_DATA_W (DW),
      .CLEAR_DATA     (FILL)
   ) dut (
      .main_clk_i                 (clk),
      .main_rst_i                 (rst),
      .start_clear_i              (start_clear),
      .filter_idle_i              (filter_idle),
      .filter_hold_o              (filter_hold),
      .clear_busy_o               (clear_busy),
      .clear_done_o               (clear_done),
      .host_lut_address_i         (host_address),
      .host_lut_write_i           (host_write),
      .host_lut_writedata_i       (host_writedata),
      .host_lut_waitrequest_o     (host_waitrequest),
      .amm_master_lut_address_o   (m_address),
      .amm_master_lut_write_o     (m_write),
      .amm_master_lut_writedata_o (m_writedata)
`ifdef BLOOM_LUT_CLEAR_STATS_EN
      ,
      .clear_cnt_o                (clear_cnt),
      .clear_drop_o               (clear_drop)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t         wq[$];
   int          dq[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          win_lo = 1;
   int          win_hi = 0;
   bit          mon_en = 0;
   logic [15:0] cnt_exp = 16'd0;
   bit          drop_exp = 0;
   bit          exp_w;
   bit          exp_d;
   bit          exp_busy;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push(int c, logic [AW-1:0] a, logic [DW-1:0] d);
      wr_t e;
      e.cyc  = c;
      e.addr = a;
      e.data = d;
      wq.push_back(e);
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         while (wq.size() > 0 && wq[0].cyc < cyc) begin
            chk("write_missing_cycle", 64'(cyc), 64'(wq[0].cyc));
            void'(wq.pop_front());
         end
         while (dq.size() > 0 && dq[0] < cyc) begin
            chk("done_missing_cycle", 64'(cyc), 64'(dq[0]));
            void'(dq.pop_front());
         end
         exp_w    = (wq.size() > 0) && (wq[0].cyc == cyc);
         exp_d    = (dq.size() > 0) && (dq[0] == cyc);
         exp_busy = (cyc >= win_lo) && (cyc <= win_hi);
         chk("master_write", 64'(m_write), 64'(exp_w));
         if (exp_w) begin
            if (m_write) begin
               chk("master_address", 64'(m_address), 64'(wq[0].addr));
               chk("master_data", 64'(m_writedata), 64'(wq[0].data));
            end
            void'(wq.pop_front());
         end
         chk("clear_done", 64'(clear_done), 64'(exp_d));
         if (exp_d) void'(dq.pop_front());
         chk("waitrequest", 64'(host_waitrequest), 64'(exp_busy));
         chk("filter_hold", 64'(filter_hold), 64'(exp_busy));
         chk("clear_busy", 64'(clear_busy), 64'(exp_busy));
      end
   end

   task automatic host_wr(logic [AW-1:0] a, logic [DW-1:0] d);
      host_address   = a;
      host_writedata = d;
      host_write     = 1'b1;
      push(cyc + 1, a, d);
      tick();
      host_write = 1'b0;
   endtask

   // The clear request is raised in cycle t. HOLD then lasts from t+1, and
   // filter_idle_i is first seen high in cycle h = t+1+L. The sweep writes
   // land in cycles h+1 .. h+16, done pulses in h+17, and the block is back
   // in IDLE at h+18.
   task automatic do_clear(int lat, bit start_mid, bit host_mid, bit host_same);
      int            t;
      int            h;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;
      t           = cyc;
      h           = t + 1 + lat;
      start_clear = 1'b1;
      filter_idle = (lat == 0);
      if (host_same) begin
         ha             = AW'($urandom);
         hd             = $urandom;
         host_address   = ha;
         host_writedata = hd;
         host_write     = 1'b1;
         push(t + 1, ha, hd);
      end
      win_lo = t + 1;
      win_hi = h + NWORD + 1;
      for (int i = 0; i < NWORD; i++) push(h + 1 + i, i[AW-1:0], FILL);
      dq.push_back(h + NWORD + 1);
      tick();
      start_clear = 1'b0;
      host_write  = 1'b0;
      while (cyc < h) tick();
      filter_idle = 1'b1;
      while (cyc < h + 3) tick();
      if (start_mid) begin
         start_clear = 1'b1;
         drop_exp    = 1'b1;
         tick();
         start_clear = 1'b0;
      end
      if (host_mid) begin
         while (cyc < h + 5) tick();
         ha             = AW'($urandom);
         hd             = $urandom;
         host_address   = ha;
         host_writedata = hd;
         host_write     = 1'b1;
         push(h + NWORD + 3, ha, hd);
         while (cyc < h + NWORD + 3) tick();
         host_write = 1'b0;
      end
      while (cyc < h + NWORD + 3) tick();
      cnt_exp = cnt_exp + 16'd1;
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_waitrequest"}, 64'(host_waitrequest), 64'd0);
      chk({tag, "_hold"}, 64'(filter_hold), 64'd0);
      chk({tag, "_busy"}, 64'(clear_busy), 64'd0);
      chk({tag, "_done"}, 64'(clear_done), 64'd0);
      chk({tag, "_write"}, 64'(m_write), 64'd0);
      chk({tag, "_address"}, 64'(m_address), 64'd0);
      chk({tag, "_data"}, 64'(m_writedata), 64'd0);
`ifdef BLOOM_LUT_CLEAR_STATS_EN
      chk({tag, "_clear_cnt"}, 64'(clear_cnt), 64'd0);
      chk({tag, "_clear_drop"}, 64'(clear_drop), 64'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int h;
      rst            = 1'b1;
      start_clear    = 1'b0;
      filter_idle    = 1'b1;
      host_address   = '0;
      host_write     = 1'b0;
      host_writedata = '0;
      #3;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      tick();

      // Basic pass-through, then a few random host writes
      host_wr(4'd3, 32'h0000_1234);
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         host_wr(AW'($urandom), $urandom);
      end
      tick();

      do_clear(0, 1'b0, 1'b0, 1'b0);
      do_clear(20, 1'b0, 1'b0, 1'b0);
      do_clear(int'($urandom_range(1, 10)), 1'b0, 1'b1, 1'b0);
      do_clear(0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         host_wr(AW'($urandom), $urandom);
         repeat ($urandom_range(0, 3)) tick();
         do_clear(int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), 1'($urandom));
      end
`ifdef BLOOM_LUT_CLEAR_STATS_EN
      chk("clear_cnt_end", 64'(clear_cnt), 64'(cnt_exp));
      chk("clear_drop_end", 64'(clear_drop), 64'(drop_exp));
`endif

      // Reset in the cycle where sweep address 7 is on the master port
      t           = cyc;
      h           = t + 1;
      start_clear = 1'b1;
      filter_idle = 1'b1;
      win_lo      = t + 1;
      win_hi      = h + NWORD + 1;
      for (int i = 0; i < NWORD; i++) push(h + 1 + i, i[AW-1:0], FILL);
      dq.push_back(h + NWORD + 1);
      tick();
      start_clear = 1'b0;
      while (cyc < h + 8) tick();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midsweep_reset");
      wq.delete();
      dq.delete();
      win_hi   = cyc;
      cnt_exp  = 16'd0;
      drop_exp = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // A fresh sweep after the reset must start again from address 0
      do_clear(2, 1'b0, 1'b0, 1'b0);
      host_wr(AW'($urandom), $urandom);
      repeat (4) tick();
`ifdef BLOOM_LUT_CLEAR_STATS_EN
      chk("clear_cnt_after_reset", 64'(clear_cnt), 64'(cnt_exp));
      chk("clear_drop_after_reset", 64'(clear_drop), 64'(drop_exp));
`endif
      chk("pending_writes", 64'(wq.size()), 64'd0);
      chk("pending_done", 64'(dq.size()), 64'd0);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
